// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// State enum, default sizes, grant-index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DSIZE = 8;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set req bit above prev, wrapping.
// Ports: req (N), prev (IW) -> found, idx (IW).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_NREQ,
  parameter int IW = idw(DEF_NREQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prev,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] hi;

  // hi keeps only requests strictly above prev; if any exist
  // they win, otherwise the lowest request wraps around.
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++)
      hi[i] = req[i] && (i > int'(prev));
  end

  always_comb begin
    found = |req;
    idx   = prev;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
    for (int i = N - 1; i >= 0; i--)
      if (hi[i]) idx = IW'(i);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked scheduler for the FIFO write port.
// Ports: wclk/wrst_n, req_* per requester, wfull/winc/wdata, gnt_*/pkt_done.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = idw(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  gnt_valid,
  output logic [IDW-1:0]        gnt_id,
  output logic                  pkt_done
);

  arb_state_t     state, state_n;
  logic [IDW-1:0] gid_n;
  logic           done_n;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           sel_valid;
  logic           sel_last;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .req   (req_valid),
    .prev  (gnt_id),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        wdata     = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt_id   <= IDW'(NREQ - 1);
      pkt_done <= 1'b0;
    end else begin
      state    <= state_n;
      gnt_id   <= gid_n;
      pkt_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    gid_n   = gnt_id;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gid_n   = pick_idx;
        end
      end
      GRANT: begin
        if (winc && sel_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // winc looks only at registered wfull and the held grant, so a
  // full FIFO can never be written, even for one cycle.
  always_comb begin
    gnt_valid = (state == GRANT);
    winc      = gnt_valid & sel_valid & ~wfull & wrst_n;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_id == IDW'(i)) req_ready[i] = winc;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Directed vector table plus packet-order and random scoreboard phases.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         wrst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [N*D-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         wfull;
  logic         winc;
  logic [D-1:0] wdata;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         pkt_done;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DSIZE (D),
    .NREQ  (N)
  ) dut (
    .wclk      (clk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .pkt_done  (pkt_done)
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       wf;
    logic       winc;
    logic [3:0] rdy;
    logic       gv;
    logic [1:0] gid;
    logic       pd;
    logic [7:0] wd;
  } vec_t;

  vec_t vec[32];

  int errors = 0;
  int checks = 0;

  logic [3:0] mv, ml, acc;
  logic [7:0] md[N];
  int         seq[N];
  int         pos[N];
  int         cur_own;
  int         wr_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic [3:0] v, input logic [3:0] l,
    input logic wf, input logic wi, input logic [3:0] rdy,
    input logic gv, input logic [1:0] gid, input logic pd,
    input logic [7:0] wd);
    vec_t t;
    t.rst = r;  t.v = v;     t.l = l;   t.wf = wf;
    t.winc = wi; t.rdy = rdy; t.gv = gv; t.gid = gid;
    t.pd = pd;  t.wd = wd;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    mv  = '0;
    ml  = '0;
    acc = '0;
    cur_own = -1;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      pos[i] = 0;
      md[i]  = '0;
    end
    repeat (2) @(negedge clk);
    wrst_n = 1'b1;
  endtask

  // Requester models hold each beat until accepted; packets are
  // 3 beats in directed mode, random length in random mode.
  task automatic model_cycle(input bit rnd);
    int own;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        mv[i]  = 1'b0;
        seq[i] = seq[i] + 1;
        pos[i] = ml[i] ? 0 : pos[i] + 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!mv[i]) begin
        if (rnd ? ($urandom_range(0, 2) != 0) : 1'b1) begin
          mv[i] = 1'b1;
          ml[i] = rnd ? ($urandom_range(0, 2) == 0) : (pos[i] == 2);
          md[i] = {2'(i), 6'(seq[i])};
        end
      end
    end
    wfull     = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    req_valid = mv;
    req_last  = ml;
    for (int i = 0; i < N; i++) req_data[i*D +: D] = md[i];
    #1;
    acc = req_ready;
    chk("ready_onehot", 32'($countones(req_ready)), 32'(winc));
    chk("ready_no_valid", 32'(req_ready & ~mv), 32'd0);
    if (winc) begin
      own = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) own = i;
      chk("write_when_full", 32'(wfull), 32'd0);
      if (own >= 0) begin
        chk("wdata_beat", 32'(wdata), 32'(md[own]));
        if (cur_own >= 0) chk("pkt_lock", own, cur_own);
        cur_own = ml[own] ? -1 : own;
      end
      wr_q.push_back(own);
    end
  endtask

  initial begin
    int cyc;
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    wfull     = 1'b0;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    acc       = '0;
    mv        = '0;
    ml        = '0;
    cur_own   = -1;

    vec[0]  = mk(0, 4'b0101, 4'b0101, 0, 0, 4'b0000, 0, 3, 0, 8'h00);
    vec[1]  = mk(1, 4'b0101, 4'b0101, 0, 0, 4'b0000, 0, 3, 0, 8'h00);
    vec[2]  = mk(1, 4'b0101, 4'b0101, 0, 1, 4'b0001, 1, 0, 0, 8'hA0);
    vec[3]  = mk(1, 4'b0101, 4'b0101, 0, 0, 4'b0000, 0, 0, 1, 8'h00);
    vec[4]  = mk(1, 4'b0101, 4'b0101, 0, 1, 4'b0100, 1, 2, 0, 8'hC2);
    vec[5]  = mk(1, 4'b0101, 4'b0101, 0, 0, 4'b0000, 0, 2, 1, 8'h00);
    vec[6]  = mk(1, 4'b0101, 4'b0101, 0, 1, 4'b0001, 1, 0, 0, 8'hA0);
    vec[7]  = mk(1, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 8'h00);
    vec[8]  = mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 8'hB1);
    for (int r = 9; r <= 13; r++)
      vec[r] = mk(1, 4'b0010, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 8'h00);
    vec[14] = mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 8'hB1);
    vec[15] = mk(1, 4'b0010, 4'b0010, 0, 1, 4'b0010, 1, 1, 0, 8'hB1);
    vec[16] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 1, 1, 8'h00);
    vec[17] = mk(1, 4'b1001, 4'b0000, 0, 0, 4'b0000, 0, 1, 0, 8'h00);
    vec[18] = mk(1, 4'b1001, 4'b0000, 0, 1, 4'b1000, 1, 3, 0, 8'hD3);
    for (int r = 19; r <= 22; r++)
      vec[r] = mk(1, 4'b0001, 4'b0000, 0, 0, 4'b0000, 1, 3, 0, 8'h00);
    vec[23] = mk(1, 4'b1001, 4'b1000, 0, 1, 4'b1000, 1, 3, 0, 8'hD3);
    vec[24] = mk(1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 3, 1, 8'h00);
    vec[25] = mk(1, 4'b0001, 4'b0001, 0, 1, 4'b0001, 1, 0, 0, 8'hA0);
    vec[26] = mk(1, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 8'h00);
    vec[27] = mk(1, 4'b0010, 4'b0000, 0, 1, 4'b0010, 1, 1, 0, 8'hB1);
    vec[28] = mk(0, 4'b0011, 4'b0000, 0, 0, 4'b0000, 1, 1, 0, 8'h00);
    vec[29] = mk(1, 4'b0011, 4'b0001, 0, 0, 4'b0000, 0, 3, 0, 8'h00);
    vec[30] = mk(1, 4'b0011, 4'b0001, 0, 1, 4'b0001, 1, 0, 0, 8'hA0);
    vec[31] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 8'h00);

    repeat (2) @(posedge clk);

    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      wrst_n    = vec[r].rst;
      req_valid = vec[r].v;
      req_last  = vec[r].l;
      wfull     = vec[r].wf;
      #1;
      chk($sformatf("row%0d winc", r), 32'(winc), 32'(vec[r].winc));
      chk($sformatf("row%0d ready", r), 32'(req_ready), 32'(vec[r].rdy));
      chk($sformatf("row%0d gnt_valid", r), 32'(gnt_valid),
          32'(vec[r].gv));
      chk($sformatf("row%0d gnt_id", r), 32'(gnt_id), 32'(vec[r].gid));
      chk($sformatf("row%0d pkt_done", r), 32'(pkt_done), 32'(vec[r].pd));
      if (vec[r].winc)
        chk($sformatf("row%0d wdata", r), 32'(wdata), 32'(vec[r].wd));
    end

    do_reset();
    wr_q.delete();
    cyc = 0;
    while (wr_q.size() < 15 && cyc < 200) begin
      model_cycle(1'b0);
      cyc++;
    end
    chk("burst_write_count", 32'(wr_q.size() >= 15), 32'd1);
    for (int k = 0; k < 15 && k < wr_q.size(); k++)
      chk($sformatf("burst_order%0d", k), wr_q[k], (k / 3) % 4);

    do_reset();
    wr_q.delete();
    for (int c = 0; c < 10000; c++) model_cycle(1'b1);
    chk("random_some_writes", 32'(wr_q.size() > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
